// File: rtl/pkt_filter_drop_pkg.sv
// Shared FSM type, header field positions and drop_reason bit indices for pkt_filter_drop.
package pkt_filter_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } fsm_state_t;

    localparam int MAC_W       = 48;
    localparam int DST_MAC_MSB = 255;
    localparam int CSUM_LSB    = 48;
    localparam int CSUM_W      = 16;
    localparam int CNT_W       = 32;

    localparam int RSN_CSUM    = 0;
    localparam int RSN_MAC     = 1;
    localparam int RSN_BCAST   = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pkt_filter_drop_if.sv
// AXI4-Stream bundle used for both the slave and master sides of pkt_filter_drop.
interface pkt_filter_drop_if #(
    parameter int DATA_W = 256,
    parameter int USER_W = 128
) ();
    logic [DATA_W-1:0]   TDATA;
    logic [DATA_W/8-1:0] TSTRB;
    logic [USER_W-1:0]   TUSER;
    logic                TVALID;
    logic                TLAST;
    logic                TREADY;

    modport master (output TDATA, TSTRB, TUSER, TVALID, TLAST, input TREADY);
    modport slave  (input TDATA, TSTRB, TUSER, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/pkt_filter_drop_fifo.sv
// Small fall-through FIFO: the head entry is visible on dout whenever empty is low.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS+1)'(DEPTH);
    localparam logic [MAX_DEPTH_BITS:0] NEAR_LVL = FULL_LVL - 1'b1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [MAX_DEPTH_BITS:0]   level;
    logic                      do_wr, do_rd;

    assign empty       = (level == '0);
    assign full        = (level == FULL_LVL);
    assign nearly_full = (level >= NEAR_LVL);
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/pkt_filter_drop.sv
// Header checksum / destination-MAC filter with per-reason counters.
// Define PKT_FILTER_DROP_ENFORCE_EN to discard failing packets; otherwise count-only.
module pkt_filter_drop
    import pkt_filter_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_PORT_POS         = 16,
    parameter int FIFO_DEPTH_BITS      = 4
) (
    input  logic                       AXI_ACLK,
    input  logic                       AXI_RESETN,
    pkt_filter_drop_if.slave           S_AXIS,
    pkt_filter_drop_if.master          M_AXIS,
    input  logic [NUM_PORTS*MAC_W-1:0] mac_addr,
    input  logic [CSUM_W-1:0]          exp_checksum,
    input  logic                       clear_counters,
    output logic [2:0]                 drop_reason,
    output logic [CNT_W-1:0]           csum_drop_count,
    output logic [CNT_W-1:0]           mac_drop_count,
    output logic [CNT_W-1:0]           fwd_count
);
    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int SW     = DW / 8;
    localparam int FIFO_W = DW + UW + SW + 1;

    fsm_state_t            state;
    logic                  in_rdy;
    logic                  fifo_full, fifo_nfull, fifo_empty, fifo_wr, fifo_rd;
    logic [FIFO_W-1:0]     fifo_dout;
    logic [DW-1:0]         head_data;
    logic [UW-1:0]         head_user;
    logic [SW-1:0]         head_strb;
    logic                  head_last;
    logic [MAC_W-1:0]      head_da;
    logic [NUM_PORTS-1:0]  port_hit, port_miss;
    logic                  checked, bcast_da, csum_fail, mac_fail, bcast_seen;
    logic                  drop_hdr, dropping, hdr_take;

    // in_rdy keeps TREADY low while reset is held, even though the FIFO looks empty.
    assign S_AXIS.TREADY = in_rdy && !fifo_nfull && !fifo_full;
    assign fifo_wr       = S_AXIS.TVALID && S_AXIS.TREADY;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk         (AXI_ACLK),
        .rst_n       (AXI_RESETN),
        .din         ({S_AXIS.TLAST, S_AXIS.TSTRB, S_AXIS.TUSER, S_AXIS.TDATA}),
        .wr_en       (fifo_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .full        (fifo_full),
        .nearly_full (fifo_nfull),
        .empty       (fifo_empty)
    );

    assign {head_last, head_strb, head_user, head_data} = fifo_dout;
    assign head_da = head_data[DST_MAC_MSB -: MAC_W];

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign port_hit[i]  = head_user[SRC_PORT_POS + 2*i];
        assign port_miss[i] = port_hit[i] && (head_da != mac_addr[MAC_W*i +: MAC_W]);
    end

    // Verdict is taken straight off the FIFO head so the header leaves with no extra cycle.
    assign checked    = |port_hit;
    assign bcast_da   = &head_da;
    assign csum_fail  = checked && (head_data[CSUM_LSB +: CSUM_W] != exp_checksum);
    assign mac_fail   = checked && !csum_fail && !bcast_da && (|port_miss);
    assign bcast_seen = checked && bcast_da;

`ifdef PKT_FILTER_DROP_ENFORCE_EN
    assign drop_hdr = csum_fail || mac_fail;
`else
    assign drop_hdr = 1'b0;
`endif

    assign dropping      = (state == DROP) || ((state == HDR) && drop_hdr);
    assign fifo_rd       = !fifo_empty && (dropping || M_AXIS.TREADY);
    assign hdr_take      = (state == HDR) && fifo_rd;

    assign M_AXIS.TVALID = !fifo_empty && !dropping;
    assign M_AXIS.TDATA  = head_data[C_M_AXIS_DATA_WIDTH-1:0];
    assign M_AXIS.TUSER  = head_user[C_M_AXIS_TUSER_WIDTH-1:0];
    assign M_AXIS.TSTRB  = head_strb;
    assign M_AXIS.TLAST  = head_last;

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            state           <= HDR;
            in_rdy          <= 1'b0;
            drop_reason     <= '0;
            csum_drop_count <= '0;
            mac_drop_count  <= '0;
            fwd_count       <= '0;
        end else begin
            in_rdy <= 1'b1;
            case (state)
                HDR:       if (fifo_rd && !head_last) state <= drop_hdr ? DROP : FWD;
                FWD, DROP: if (fifo_rd && head_last)  state <= HDR;
                default:   state <= HDR;
            endcase

            if (hdr_take) begin
                drop_reason[RSN_BCAST] <= bcast_seen;
                drop_reason[RSN_MAC]   <= mac_fail;
                drop_reason[RSN_CSUM]  <= csum_fail;
            end

            // Clear beats an increment landing on the same edge.
            if (clear_counters) begin
                csum_drop_count <= '0;
                mac_drop_count  <= '0;
                fwd_count       <= '0;
            end else if (hdr_take) begin
                if (csum_fail)     csum_drop_count <= sat_inc(csum_drop_count);
                else if (mac_fail) mac_drop_count  <= sat_inc(mac_drop_count);
                else               fwd_count       <= sat_inc(fwd_count);
            end
        end
    end
endmodule

// File: tb/tb_pkt_filter_drop.sv
// Randomized and directed bench for pkt_filter_drop against a packet-level reference model.
module tb_pkt_filter_drop;
    import pkt_filter_pkg::*;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int NP  = 4;
    localparam int SPP = 16;
`ifdef PKT_FILTER_DROP_ENFORCE_EN
    localparam bit ENF = 1'b1;
`else
    localparam bit ENF = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0]   d;
        logic [UW-1:0]   u;
        logic [DW/8-1:0] s;
        logic            l;
    } beat_t;

    logic            AXI_ACLK = 1'b0;
    logic            AXI_RESETN;
    logic [NP*48-1:0] mac_addr;
    logic [15:0]     exp_checksum;
    logic            clear_counters;
    logic [2:0]      drop_reason;
    logic [31:0]     csum_drop_count, mac_drop_count, fwd_count;

    pkt_filter_drop_if #(.DATA_W(DW), .USER_W(UW)) s_axis ();
    pkt_filter_drop_if #(.DATA_W(DW), .USER_W(UW)) m_axis ();

    pkt_filter_drop #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .NUM_PORTS(NP), .SRC_PORT_POS(SPP), .FIFO_DEPTH_BITS(4)
    ) dut (
        .AXI_ACLK        (AXI_ACLK),
        .AXI_RESETN      (AXI_RESETN),
        .S_AXIS          (s_axis),
        .M_AXIS          (m_axis),
        .mac_addr        (mac_addr),
        .exp_checksum    (exp_checksum),
        .clear_counters  (clear_counters),
        .drop_reason     (drop_reason),
        .csum_drop_count (csum_drop_count),
        .mac_drop_count  (mac_drop_count),
        .fwd_count       (fwd_count)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    int      n_vec = 0;
    int      n_err = 0;
    beat_t   pkt[$];
    beat_t   exp_q[$];
    beat_t   act_q[$];
    beat_t   mon_b;
    longint  m_csum, m_mac, m_fwd;
    logic [2:0] m_rsn;
    bit      rnd_done;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // A beat transfers on the next rising edge if valid and ready are both up at the falling edge.
    always @(negedge AXI_ACLK) begin
        if (AXI_RESETN && m_axis.TVALID && m_axis.TREADY) begin
            mon_b.d = m_axis.TDATA;
            mon_b.u = m_axis.TUSER;
            mon_b.s = m_axis.TSTRB;
            mon_b.l = m_axis.TLAST;
            act_q.push_back(mon_b);
        end
    end

    // Reference verdict {bcast, mac_fail, csum_fail} straight from the filtering rules.
    function automatic logic [2:0] ref_verdict(input beat_t h);
        bit any = 0, miss = 0, bc;
        logic [47:0] da;
        da = h.d[255:208];
        bc = (da == 48'hFFFF_FFFF_FFFF);
        for (int i = 0; i < NP; i++)
            if (h.u[SPP + 2*i]) begin
                any = 1;
                if (da != mac_addr[48*i +: 48]) miss = 1;
            end
        if (!any) return 3'b000;
        if (h.d[63:48] != exp_checksum) return {bc, 2'b01};
        return {bc, miss && !bc, 1'b0};
    endfunction

    function automatic longint sat(input longint v);
        return (v < 64'hFFFF_FFFF) ? v + 1 : v;
    endfunction

    task automatic model_pkt();
        logic [2:0] v;
        v = ref_verdict(pkt[0]);
        m_rsn = v;
        if (v[0])      m_csum = sat(m_csum);
        else if (v[1]) m_mac  = sat(m_mac);
        else           m_fwd  = sat(m_fwd);
        if (!ENF || !(v[0] || v[1]))
            foreach (pkt[i]) exp_q.push_back(pkt[i]);
    endtask

    task automatic mk_pkt(input int nb, input logic [UW-1:0] hu, input logic [47:0] da,
                          input logic [15:0] cs);
        beat_t b;
        pkt.delete();
        for (int i = 0; i < nb; i++) begin
            b.d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            b.u = {$urandom, $urandom, $urandom, $urandom};
            b.s = $urandom;
            b.l = (i == nb - 1);
            if (i == 0) begin
                b.d[255:208] = da;
                b.d[63:48]   = cs;
                b.u          = hu;
            end
            pkt.push_back(b);
        end
    endtask

    // Called and returns one time unit after a rising edge; nmax < size cuts the packet short.
    task automatic send_pkt(input int gap, input int nmax);
        if (nmax >= pkt.size()) model_pkt();
        for (int i = 0; i < pkt.size() && i < nmax; i++) begin
            int w;
            s_axis.TVALID = 1'b0;
            if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge AXI_ACLK); #1; end
            s_axis.TDATA  = pkt[i].d;
            s_axis.TUSER  = pkt[i].u;
            s_axis.TSTRB  = pkt[i].s;
            s_axis.TLAST  = pkt[i].l;
            s_axis.TVALID = 1'b1;
            w = 0;
            while (!s_axis.TREADY && w < 1000) begin @(posedge AXI_ACLK); #1; w++; end
            if (w >= 1000) chk("s_tready_stuck", s_axis.TREADY, 1);
            @(posedge AXI_ACLK); #1;
        end
        s_axis.TVALID = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        m_axis.TREADY = 1'b1;
        repeat (40) begin @(posedge AXI_ACLK); #1; end
        chk({tag, "_nbeats"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk({tag, "_data"}, act_q[i].d, exp_q[i].d);
            chk({tag, "_side"}, {act_q[i].u, act_q[i].s, act_q[i].l},
                                {exp_q[i].u, exp_q[i].s, exp_q[i].l});
        end
        chk({tag, "_csum_cnt"}, csum_drop_count, m_csum[31:0]);
        chk({tag, "_mac_cnt"},  mac_drop_count,  m_mac[31:0]);
        chk({tag, "_fwd_cnt"},  fwd_count,       m_fwd[31:0]);
        chk({tag, "_reason"},   drop_reason,     m_rsn);
        exp_q.delete();
        act_q.delete();
    endtask

    function automatic logic [UW-1:0] port_bit(input int p);
        logic [UW-1:0] u;
        u = '0;
        u[SPP + 2*p] = 1'b1;
        return u;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [47:0] mac0;
        int          w;
        AXI_RESETN     = 1'b0;
        s_axis.TVALID  = 1'b0;
        s_axis.TDATA   = '0;
        s_axis.TUSER   = '0;
        s_axis.TSTRB   = '0;
        s_axis.TLAST   = 1'b0;
        m_axis.TREADY  = 1'b0;
        clear_counters = 1'b0;
        mac_addr       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mac0           = mac_addr[47:0];
        exp_checksum   = 16'hABCD;
        m_csum = 0; m_mac = 0; m_fwd = 0; m_rsn = 3'b000;

        repeat (2) @(posedge AXI_ACLK);
        #1;
        chk("rst_s_tready", s_axis.TREADY, 0);
        chk("rst_m_tvalid", m_axis.TVALID, 0);
        AXI_RESETN = 1'b1;
        @(posedge AXI_ACLK); #1;
        chk("post_rst_fwd",    fwd_count, 0);
        chk("post_rst_csum",   csum_drop_count, 0);
        chk("post_rst_reason", drop_reason, 0);
        chk("post_rst_tready", s_axis.TREADY, 1);

        // Directed headers: good, bad checksum, MAC miss, broadcast, unchecked, single-beat bad.
        m_axis.TREADY = 1'b1;
        mk_pkt(3, port_bit(0), mac0, 16'hABCD);             send_pkt(0, 99); drain_check("good3");
        mk_pkt(3, port_bit(0), mac0, 16'h1234);             send_pkt(0, 99); drain_check("bad_csum");
        mk_pkt(3, port_bit(2), 48'h0200_0000_0099, 16'hABCD); send_pkt(0, 99); drain_check("mac_miss");
        mk_pkt(3, port_bit(2), 48'hFFFF_FFFF_FFFF, 16'hABCD); send_pkt(0, 99); drain_check("bcast");
        mk_pkt(2, '0, 48'h0200_0000_0001, 16'h5555);        send_pkt(0, 99); drain_check("unchecked");
        mk_pkt(1, port_bit(1), mac0, 16'h0001);             send_pkt(0, 99);
        mk_pkt(2, port_bit(0), mac0, 16'hABCD);             send_pkt(0, 99); drain_check("single_beat");

        // Bad 4-beat packet then good one while the output is stalled.
        m_axis.TREADY = 1'b0;
        mk_pkt(4, port_bit(0), mac0, 16'h1234); send_pkt(0, 99);
        mk_pkt(3, port_bit(0), mac0, 16'hABCD); send_pkt(0, 99);
        w = 0;
        while (!m_axis.TVALID && w < 12) begin @(posedge AXI_ACLK); #1; w++; end
        chk("stall_tvalid", m_axis.TVALID, 1);
        chk("stall_head",   m_axis.TDATA, exp_q[0].d);
        repeat (10) begin @(posedge AXI_ACLK); #1; end
        chk("stall_hold_tvalid", m_axis.TVALID, 1);
        chk("stall_hold_head",   m_axis.TDATA, exp_q[0].d);
        drain_check("stall");

        // Random packets under random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [UW-1:0] hu;
                    logic [47:0]   da;
                    logic [63:0]   r;
                    int            p;
                    hu = {$urandom, $urandom, $urandom, $urandom};
                    p  = $urandom_range(0, NP - 1);
                    for (int i = 0; i < NP; i++) hu[SPP + 2*i] = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 1) == 1) begin
                        for (int i = 0; i < NP; i++) hu[SPP + 2*i] = 1'b0;
                        if ($urandom_range(0, 4) != 0) hu[SPP + 2*p] = 1'b1;
                    end
                    r = {$urandom, $urandom};
                    case ($urandom_range(0, 4))
                        0, 1:    da = mac_addr[48*p +: 48];
                        2:       da = 48'hFFFF_FFFF_FFFF;
                        default: da = r[47:0];
                    endcase
                    mk_pkt($urandom_range(1, 5), hu, da,
                           ($urandom_range(0, 1) == 1) ? 16'hABCD : r[63:48]);
                    send_pkt(2, 99);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    m_axis.TREADY = ($urandom_range(0, 3) != 0);
                    @(posedge AXI_ACLK); #1;
                end
            end
        join
        drain_check("random");

        // Saturation: preset the checksum-drop counter, then one more bad packet.
        force dut.csum_drop_count = 32'hFFFF_FFFF;
        @(posedge AXI_ACLK); #1;
        release dut.csum_drop_count;
        m_csum = 64'hFFFF_FFFF;
        mk_pkt(2, port_bit(3), mac_addr[191:144], 16'h0BAD); send_pkt(0, 99);
        drain_check("saturate");

        // Clear on the same edge that consumes a header: clear wins.
        mk_pkt(1, port_bit(0), mac0, 16'hABCD); send_pkt(0, 99);
        clear_counters = 1'b1;
        @(posedge AXI_ACLK); #1;
        clear_counters = 1'b0;
        m_csum = 0; m_mac = 0; m_fwd = 0;
        drain_check("clear");

        // Reset in the middle of a 5-beat packet; the next packet must come through whole.
        m_axis.TREADY = 1'b0;
        mk_pkt(5, port_bit(0), mac0, 16'hABCD); send_pkt(0, 2);
        AXI_RESETN = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_axis.TVALID, 0);
        chk("midrst_s_tready", s_axis.TREADY, 0);
        chk("midrst_mac_cnt",  mac_drop_count, 0);
        repeat (2) @(posedge AXI_ACLK);
        #1;
        AXI_RESETN = 1'b1;
        exp_q.delete(); act_q.delete();
        m_csum = 0; m_mac = 0; m_fwd = 0; m_rsn = 3'b000;
        @(posedge AXI_ACLK); #1;
        m_axis.TREADY = 1'b1;
        mk_pkt(5, port_bit(0), mac0, 16'hABCD); send_pkt(0, 99);
        drain_check("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
